spectrum_frame_writer: RTL

SPECTRUM_FRAME_WRITER -- requirements
Module: spectrum_frame_writer

---
 rtl/spectrum_frame_writer.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/spectrum_frame_writer.sv
// spectrum_frame_writer
//
// Accepts one frame of FFT bin magnitudes and writes a scaled, clamped bar
// height per bin into the display buffer. It then hands the buffer to the
// display with a one-cycle start pulse. It does not accept the next frame
// until the display has finished copying the buffer.
//
// Build option: define PEAK_HOLD_EN for peak-hold mode. In that mode each bar
// decays by one per frame instead of dropping straight to the new value.
//
// Ports
//   clk                 pixel clock, the only clock
//   rst_n               asynchronous active-low reset
//   fft_valid_i         input bin valid
//   fft_ready_o         block can accept a bin
//   fft_mag_i           unsigned bin magnitude (MAG_W bits)
//   fft_last_i          final bin of a frame
//   shift_i             right-shift scale, sampled on the first bin of a frame
//   vga_buff_reading_i  display is copying the buffer
//   buff_wen_o          buffer write enable
//   buff_wadd_o         buffer write address (bin index)
//   buff_wdata_o        buffer write data (bar height, zero-extended)
//   display_start_o     one-cycle pulse: frame ready to draw
//   frame_err_o         sticky framing error, cleared only by reset
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FILL      | accepting bins and writing bar heights
// COMMIT    | frame complete, waiting for the last write to retire
// HOLD_WAIT | start pulse issued, waiting for the display to begin reading
// HOLD_BUSY | display reading, buffer must not be overwritten
module spectrum_frame_writer #(
  parameter int NUM_BINS   = 1024,
  parameter int MAX_HEIGHT = 511,
  parameter int MAG_W      = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fft_valid_i,
  output logic             fft_ready_o,
  input  logic [MAG_W-1:0] fft_mag_i,
  input  logic             fft_last_i,
  input  logic [4:0]       shift_i,
  input  logic             vga_buff_reading_i,
  output logic             buff_wen_o,
  output logic [9:0]       buff_wadd_o,
  output logic [15:0]      buff_wdata_o,
  output logic             display_start_o,
  output logic             frame_err_o
);

  localparam int CNT_W = $clog2(NUM_BINS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BINS - 1);
  localparam logic [MAG_W-1:0] MAX_H_M  = MAG_W'(MAX_HEIGHT);
`ifdef PEAK_HOLD_EN
  localparam int H_W = 9;
`else
  localparam int H_W = 16;
`endif

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    COMMIT    = 2'd1,
    HOLD_WAIT = 2'd2,
    HOLD_BUSY = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       shift_q, shift_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             wen_q, wen_d;
  logic [9:0]       wadd_q, wadd_d;
  logic [15:0]      wdata_q, wdata_d;

  logic             accept;
  logic             at_last;
  logic             wr_pending;
  logic             clr_busy_d;
  logic [4:0]       shift_eff;
  logic             shift_ovf;
  logic [MAG_W-1:0] mag_shifted;
  logic [H_W-1:0]   height;

  assign accept  = fft_valid_i && ready_q && (state_q == FILL);
  assign at_last = (cnt_q == LAST_IDX);

  // The scale is latched on the first bin. Later bins of the same frame use
  // the latched value, so a mid-frame change of shift_i has no effect.
  assign shift_eff   = (cnt_q == '0) ? shift_i : shift_q;
  assign shift_ovf   = (int'(shift_eff) >= MAG_W);
  assign mag_shifted = fft_mag_i >> shift_eff;
  assign height      = shift_ovf ? '0 :
                       (mag_shifted > MAX_H_M) ? H_W'(MAX_HEIGHT) : H_W'(mag_shifted);

`ifdef PEAK_HOLD_EN
  logic [8:0]       peak_mem [NUM_BINS];
  logic             s1_vld_q;
  logic [CNT_W-1:0] s1_addr_q;
  logic [8:0]       s1_new_q;
  logic             clr_busy_q;
  logic [CNT_W-1:0] clr_cnt_q;
  logic [8:0]       peak_rd, peak_dec, merged;

  // The peak is read combinationally in stage 1 and written back on the same
  // edge that retires stage 1. A back-to-back access to the same bin
  // therefore always sees the updated peak.
  assign peak_rd    = peak_mem[s1_addr_q];
  assign peak_dec   = (peak_rd == 9'd0) ? 9'd0 : peak_rd - 9'd1;
  assign merged     = (s1_new_q > peak_dec) ? s1_new_q : peak_dec;
  assign clr_busy_d = clr_busy_q && (clr_cnt_q != LAST_IDX);
  assign wr_pending = s1_vld_q || wen_q;

  assign wen_d   = s1_vld_q;
  assign wadd_d  = s1_vld_q ? 10'(s1_addr_q) : wadd_q;
  assign wdata_d = s1_vld_q ? 16'(merged) : wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_addr_q  <= '0;
      s1_new_q   <= '0;
      clr_busy_q <= 1'b1;
      clr_cnt_q  <= '0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_addr_q <= cnt_q;
        s1_new_q  <= height;
      end
      clr_busy_q <= clr_busy_d;
      if (clr_busy_q) clr_cnt_q <= clr_cnt_q + CNT_W'(1);
    end
  end

  // No bins are accepted during the clear sweep, so the two write sources
  // never collide.
  always_ff @(posedge clk) begin
    if (clr_busy_q) begin
      peak_mem[clr_cnt_q] <= 9'd0;
    end else if (s1_vld_q) begin
      peak_mem[s1_addr_q] <= merged;
    end
  end
`else
  assign clr_busy_d = 1'b0;
  assign wr_pending = wen_q;

  assign wen_d   = accept;
  assign wadd_d  = accept ? 10'(cnt_q) : wadd_q;
  assign wdata_d = accept ? 16'(height) : wdata_q;
`endif

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    shift_d         = shift_q;
    err_d           = err_q;
    display_start_o = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (cnt_q == '0) shift_d = shift_i;
          if (at_last) begin
            // A full count ends the frame even without fft_last_i.
            cnt_d   = '0;
            state_d = COMMIT;
            if (!fft_last_i) err_d = 1'b1;
          end else if (fft_last_i) begin
            // The frame is short: drop it and resynchronise on the next bin.
            cnt_d = '0;
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      COMMIT: begin
        // The start pulse is gated live by the reading flag, so it can never
        // overlap a buffer copy or an outstanding write.
        if (!wr_pending && !vga_buff_reading_i) begin
          display_start_o = 1'b1;
          state_d         = HOLD_WAIT;
        end
      end
      HOLD_WAIT: begin
        if (vga_buff_reading_i) state_d = HOLD_BUSY;
      end
      HOLD_BUSY: begin
        if (!vga_buff_reading_i) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  assign ready_d = (state_d == FILL) && !clr_busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      shift_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
      wadd_q  <= '0;
      wdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      wen_q   <= wen_d;
      wadd_q  <= wadd_d;
      wdata_q <= wdata_d;
    end
  end

  assign fft_ready_o  = ready_q;
  assign buff_wen_o   = wen_q;
  assign buff_wadd_o  = wadd_q;
  assign buff_wdata_o = wdata_q;
  assign frame_err_o  = err_q;

endmodule
